spart_driver: RTL

SPART_DRIVER -- requirements
Module: spart_driver

---
 rtl/spart_pkg.sv | 24 ++
 rtl/baud_div_sel.sv | 24 ++
 rtl/spart_driver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared SPART definitions: driver FSM states, bus register addresses and default
// baud divisors for a 100 MHz clock with 16x oversampling.
package spart_pkg;

  typedef enum logic [2:0] {
    INIT_LO  = 3'd0,
    INIT_HI  = 3'd1,
    IDLE     = 3'd2,
    READ     = 3'd3,
    WAIT_TBR = 3'd4,
    WRITE    = 3'd5
  } state_t;

  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  localparam logic [15:0] DEF_DIV_4800  = 16'h0516;
  localparam logic [15:0] DEF_DIV_9600  = 16'h028B;
  localparam logic [15:0] DEF_DIV_19200 = 16'h0145;
  localparam logic [15:0] DEF_DIV_38400 = 16'h00A2;

endpackage

// File: rtl/baud_div_sel.sv
// Maps the two-bit baud-rate select onto the 16-bit SPART divisor.
module baud_div_sel
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_4800  = DEF_DIV_4800,
  parameter logic [15:0] DIV_9600  = DEF_DIV_9600,
  parameter logic [15:0] DIV_19200 = DEF_DIV_19200,
  parameter logic [15:0] DIV_38400 = DEF_DIV_38400
) (
  input  logic [1:0]  i_br_cfg,
  output logic [15:0] o_divisor
);

  always_comb begin
    o_divisor = DIV_4800;
    case (i_br_cfg)
      2'b00:   o_divisor = DIV_4800;
      2'b01:   o_divisor = DIV_9600;
      2'b10:   o_divisor = DIV_19200;
      default: o_divisor = DIV_38400;
    endcase
  end

endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor, then echoes every received byte
// back to the transmitter. Bus controls are registered alongside the state.
module spart_driver
  import spart_pkg::*;
#(
  parameter logic [15:0] DIV_4800  = DEF_DIV_4800,
  parameter logic [15:0] DIV_9600  = DEF_DIV_9600,
  parameter logic [15:0] DIV_19200 = DEF_DIV_19200,
  parameter logic [15:0] DIV_38400 = DEF_DIV_38400
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  output logic [7:0] echo_cnt,
  output logic [7:0] last_byte
);

  state_t      r_state;
  logic        r_iocs;
  logic        r_iorw;
  logic [1:0]  r_ioaddr;
  logic [7:0]  r_echo_cnt;
  logic [7:0]  r_last_byte;
  logic [1:0]  r_cfg_q;
  logic [15:0] w_divisor;
  logic [7:0]  w_dout;

  baud_div_sel #(
    .DIV_4800 (DIV_4800),
    .DIV_9600 (DIV_9600),
    .DIV_19200(DIV_19200),
    .DIV_38400(DIV_38400)
  ) u_baud_div_sel (
    .i_br_cfg (br_cfg),
    .o_divisor(w_divisor)
  );

  // INIT_LO with iocs low means "just left reset": issue the low-byte write
  // from there instead of advancing, so the first access is always INIT_LO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= INIT_LO;
      r_iocs      <= 1'b0;
      r_iorw      <= 1'b1;
      r_ioaddr    <= ADDR_DATA;
      r_echo_cnt  <= 8'h00;
      r_last_byte <= 8'h00;
      r_cfg_q     <= 2'b00;
    end else begin
      r_iocs   <= 1'b0;
      r_iorw   <= 1'b1;
      r_ioaddr <= ADDR_DATA;
      case (r_state)
        INIT_LO: begin
          r_iocs <= 1'b1;
          r_iorw <= 1'b0;
          if (!r_iocs) begin
            r_ioaddr <= ADDR_DIV_LO;
          end else begin
            r_state  <= INIT_HI;
            r_ioaddr <= ADDR_DIV_HI;
          end
        end
        INIT_HI: begin
          r_cfg_q <= br_cfg;
          r_state <= IDLE;
        end
        IDLE: begin
          if (br_cfg != r_cfg_q) begin
            r_state  <= INIT_LO;
            r_iocs   <= 1'b1;
            r_iorw   <= 1'b0;
            r_ioaddr <= ADDR_DIV_LO;
          end else if (rda) begin
            r_state <= READ;
            r_iocs  <= 1'b1;
          end
        end
        READ: begin
          r_last_byte <= databus;
          r_state     <= WAIT_TBR;
        end
        WAIT_TBR: begin
          if (tbr) begin
            r_state <= WRITE;
            r_iocs  <= 1'b1;
            r_iorw  <= 1'b0;
          end
        end
        WRITE: begin
          r_echo_cnt <= r_echo_cnt + 8'd1;
          r_state    <= IDLE;
        end
        default: r_state <= INIT_LO;
      endcase
    end
  end

  // Divisor bytes follow the live br_cfg while programming.
  always_comb begin
    w_dout = r_last_byte;
    case (r_state)
      INIT_LO: w_dout = w_divisor[7:0];
      INIT_HI: w_dout = w_divisor[15:8];
      default: w_dout = r_last_byte;
    endcase
  end

  assign databus   = (r_iocs && !r_iorw) ? w_dout : 8'hzz;
  assign iocs      = r_iocs;
  assign iorw      = r_iorw;
  assign ioaddr    = r_ioaddr;
  assign echo_cnt  = r_echo_cnt;
  assign last_byte = r_last_byte;

endmodule
